// File: rtl/fb_exstage.sv
`default_nettype none
// ============================================================================
//  Module   : fb_exstage
//  Purpose  : Execute stage of the Firebird pipeline. Consumes the ID/EX
//             register outputs and produces the result, store data and branch
//             decision for EX/MEM. RAW hazards are resolved by forwarding from
//             MEM (highest priority) and WB. Also contains an iterative
//             shift-add multiplier. While a multiply runs, busy freezes
//             IF/ID and ID/EX and bubbles are inserted into EX/MEM.
//  Ports    :
//    clk, rst              clock, synchronous active-high reset
//    flush                 kill the instruction in EX (aborts a multiply)
//    in_valid              ID/EX holds a real instruction
//    alu_op                00 ADD, 01 SUB, 10 AND, 11 OR
//    alu_src               1: operand B is imm
//    alu_res_src           1: result is pc_add_1 (link value)
//    branch                conditional branch, taken when A == B
//    mul_en                instruction is MUL (low XLEN bits of product)
//    pc_add_1, rs1_data, rs2_data, imm           ID/EX operand fields
//    register_rs1, register_rs2                  source register numbers
//    mem_reg_write, mem_rd, mem_alu_res          MEM forward source
//    wb_reg_write, wb_rd, wb_data                WB forward source
//    ex_result, ex_store_data, ex_branch_taken   values for EX/MEM
//    ex_valid              EX/MEM must capture this cycle
//    busy                  stall request (multiply in progress)
//  Revision : 1.0  initial release
// ============================================================================
module fb_exstage #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [1:0]      alu_op,
    input  logic            alu_src,
    input  logic            alu_res_src,
    input  logic            branch,
    input  logic            mul_en,
    input  logic [XLEN-1:0] pc_add_1,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    input  logic [4:0]      register_rs1,
    input  logic [4:0]      register_rs2,
    input  logic            mem_reg_write,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_alu_res,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] ex_result,
    output logic [XLEN-1:0] ex_store_data,
    output logic            ex_branch_taken,
    output logic            ex_valid,
    output logic            busy
);

    localparam logic [1:0] C_OP_ADD = 2'b00;
    localparam logic [1:0] C_OP_SUB = 2'b01;
    localparam logic [1:0] C_OP_AND = 2'b10;
    localparam logic [1:0] C_OP_OR  = 2'b11;

    // Counter value on the final multiplier iteration.
    localparam logic [4:0] C_CNT_LAST = 5'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [4:0]      r_cnt;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_prod;

    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic [XLEN-1:0] w_op_a;
    logic [XLEN-1:0] w_op_b;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_alu_res;
    logic            w_mul_start;

    // ------------------------------------------------------------------
    // Forwarding: MEM wins over WB; x0 is never forwarded.
    // ------------------------------------------------------------------
    always_comb begin
        w_fwd_rs1 = rs1_data;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == register_rs1)) begin
            w_fwd_rs1 = mem_alu_res;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == register_rs1)) begin
            w_fwd_rs1 = wb_data;
        end
    end

    always_comb begin
        w_fwd_rs2 = rs2_data;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == register_rs2)) begin
            w_fwd_rs2 = mem_alu_res;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == register_rs2)) begin
            w_fwd_rs2 = wb_data;
        end
    end

    assign w_op_a        = w_fwd_rs1;
    assign w_op_b        = alu_src ? imm : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign w_diff        = w_op_a - w_op_b;

    always_comb begin
        w_alu_res = w_op_a + w_op_b;
        case (alu_op)
            C_OP_ADD: w_alu_res = w_op_a + w_op_b;
            C_OP_SUB: w_alu_res = w_diff;
            C_OP_AND: w_alu_res = w_op_a & w_op_b;
            C_OP_OR:  w_alu_res = w_op_a | w_op_b;
            default:  w_alu_res = w_op_a + w_op_b;
        endcase
    end

    assign ex_branch_taken = in_valid & branch & ~flush & (w_diff == '0);

    // ------------------------------------------------------------------
    // Result mux: finished product beats link value beats ALU.
    // ------------------------------------------------------------------
    always_comb begin
        ex_result = w_alu_res;
        if (r_state == S_DONE) begin
            ex_result = r_prod;
        end else if (alu_res_src) begin
            ex_result = pc_add_1;
        end
    end

    // ------------------------------------------------------------------
    // Multiplier control. The stall is raised combinationally in the
    // cycle a MUL first appears so ID/EX holds it while the FSM runs;
    // the DONE cycle releases the stall and presents the product.
    // ------------------------------------------------------------------
    assign w_mul_start = (r_state == S_IDLE) & in_valid & mul_en & ~flush;
    assign busy        = w_mul_start | (r_state == S_RUN);
    assign ex_valid    = in_valid & ~busy & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: w_next_state = w_mul_start ? S_RUN : S_IDLE;
            S_RUN: begin
                if (flush) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operands are captured once at start; forward-source changes while
    // running cannot disturb the product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 5'd0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
        end else if (w_mul_start) begin
            r_cnt    <= 5'd0;
            r_mcand  <= w_op_a;
            r_mplier <= w_op_b;
            r_prod   <= '0;
        end else if ((r_state == S_RUN) && !flush) begin
            if (r_mplier[0]) begin
                r_prod <= r_prod + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 5'd1;
        end
    end

endmodule
`default_nettype wire
